// File: rtl/hazard_controller.sv
// hazard_controller: pipeline interlock and sequencing for the 5-stage core.
// Tracks the destinations in flight (EX/MEM/WB shadow), detects RAW hazards,
// handles taken-branch flushes and data-memory freezes, and counts stall cycles.
// Build option: define HAZARD_CTRL_FORWARDING_EN for a core with a forwarding
// unit (only load-use stalls). Without it, every RAW hazard against EX, MEM or
// WB interlocks and hazard_en is held at 1.
module hazard_controller #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_is_load,
  input  logic             br_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_en,
  output logic             hazard_en,
  output logic [REG_W-1:0] ex_op_dest,
  output logic [REG_W-1:0] mem_op_dest,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

`ifdef HAZARD_CTRL_FORWARDING_EN
  localparam logic HZ_IDLE = 1'b0;
`else
  localparam logic HZ_IDLE = 1'b1;
`endif

  state_e           state_q, state_d;
  logic [REG_W-1:0] ex_dest_q, ex_dest_d;
  logic [REG_W-1:0] mem_dest_q, mem_dest_d;
  logic [REG_W-1:0] wb_dest_q, wb_dest_d;
  logic             ex_is_load_q, ex_is_load_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             stall_req;

`ifdef HAZARD_CTRL_FORWARDING_EN
  // A load still in EX has no data to forward yet; its consumer in ID must wait.
  assign stall_req = id_valid && ex_is_load_q && (ex_dest_q != '0) &&
                     ((id_src1 == ex_dest_q) || (id_src2 == ex_dest_q));

  logic unused_wb_dest;
  assign unused_wb_dest = ^wb_dest_q;
`else
  // Without forwarding, any nonzero source still owed by EX, MEM or WB interlocks.
  logic src1_hit, src2_hit;
  assign src1_hit = (id_src1 != '0) &&
                    ((id_src1 == ex_dest_q) || (id_src1 == mem_dest_q) || (id_src1 == wb_dest_q));
  assign src2_hit = (id_src2 != '0) &&
                    ((id_src2 == ex_dest_q) || (id_src2 == mem_dest_q) || (id_src2 == wb_dest_q));
  assign stall_req = id_valid && (src1_hit || src2_hit);

  logic unused_ex_is_load;
  assign unused_ex_is_load = ex_is_load_q;
`endif

  // Next state and pipeline controls; mem_busy outranks br_taken, which outranks a stall.
  always_comb begin
    // NOTE: every output gets a default before any branch so no path can infer a latch.
    state_d     = RUN;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    pipe_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    hazard_en   = HZ_IDLE;
    if (mem_busy) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      pipe_en = 1'b0;
      state_d = MEM_WAIT;
      if (state_q == MEM_WAIT) hazard_en = 1'b1;
    end else if ((state_q != LU_STALL) && br_taken) begin
      // The ID instruction is squashed, so any hazard it carried is moot.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      hazard_en   = 1'b1;
    end else if ((state_q != LU_STALL) && stall_req) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      hazard_en   = 1'b1;
`ifdef HAZARD_CTRL_FORWARDING_EN
      state_d     = LU_STALL;
`endif
    end
    // Reset releases a frozen pipeline immediately, not at the next edge.
    if (!rst_n) begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      pipe_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      hazard_en   = HZ_IDLE;
    end
  end

  // Shadow pipeline advance and saturating stall counter.
  always_comb begin
    ex_dest_d      = ex_dest_q;
    ex_is_load_d   = ex_is_load_q;
    mem_dest_d     = mem_dest_q;
    wb_dest_d      = wb_dest_q;
    stall_cycles_d = stall_cycles_q;
    if (pipe_en) begin
      wb_dest_d    = mem_dest_q;
      mem_dest_d   = ex_dest_q;
      ex_dest_d    = (id_valid && !idex_bubble) ? id_dest : '0;
      ex_is_load_d = id_valid && !idex_bubble && id_is_load;
    end
    if (!pc_en && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  // State, shadow and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q        <= RUN;
      ex_dest_q      <= '0;
      ex_is_load_q   <= 1'b0;
      mem_dest_q     <= '0;
      wb_dest_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      ex_dest_q      <= ex_dest_d;
      ex_is_load_q   <= ex_is_load_d;
      mem_dest_q     <= mem_dest_d;
      wb_dest_q      <= wb_dest_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign ex_op_dest   = ex_dest_q;
  assign mem_op_dest  = mem_dest_q;
  assign stall_cycles = stall_cycles_q;

endmodule
